hba_master_arbiter: RTL and testbench
=====================================

# hba_master_arbiter

Round-robin arbiter that shares the single HBA slave bus between up to four HBA masters, such as `serial_fpga` and a second bus master. It sits between the masters and the slave bank. It grants bus ownership to one master at a time and muxes that master's address, write data, rnw and select onto the shared bus. It routes the slave's `xferack` back to the owner only. A compile-time watchdog can force release from a master that holds the bus too long.

## Interface
- `NUM_MASTERS`, 2: number of requesters, legal range 2..4.
- `DBUS_WIDTH`, 8: HBA data bus width.
- `PERIPH_ADDR_WIDTH`, 4: peripheral select field width.
- `REG_ADDR_WIDTH`, 8: register address field width. `ADDR_WIDTH` = `PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH` = 12.
- `MAX_HOLD`, 256: watchdog limit in cycles. Power of two, at least 4.

- `clk`  in  1  system clock. Everything is sampled on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `master_req`  in  NUM_MASTERS  bus request, one bit per master.
- `master_gnt`  out  NUM_MASTERS  one-hot grant, registered.
- `master_abus`  in  NUM_MASTERS*ADDR_WIDTH  packed addresses. Master i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `master_dbus_out`  in  NUM_MASTERS*DBUS_WIDTH  packed write data.
- `master_rnw`  in  NUM_MASTERS  read-not-write.
- `master_select`  in  NUM_MASTERS  transfer strobe.
- `master_xferack`  out  NUM_MASTERS  ack routed to the owner.
- `hba_abus`  out  ADDR_WIDTH  shared address.
- `hba_dbus`  out  DBUS_WIDTH  shared write data.
- `hba_rnw`  out  1  shared rnw.
- `hba_select`  out  1  shared select.
- `hba_xferack`  in  1  slave transfer acknowledge.
- `timeout_err`  out  1  one-cycle pulse on a forced release.

## Operation
- The FSM has two states: IDLE and BUSY. Registers: `owner` (index), `last` (index of most recent owner), hold counter.
- IDLE, any `master_req` high:
  - Search upward from `last+1`, wrapping modulo NUM_MASTERS.
  - Grant the first master found with `req` high.
  - Set `master_gnt[owner]`, set `last` = owner, clear the counter, go to BUSY.
- BUSY, owner's `req` low and owner's `select` low: clear `master_gnt`, go to IDLE.
- Requests from other masters are ignored while in BUSY.
- Shared bus mux:
  - Shared outputs combinationally reflect the owner's inputs only while `master_gnt` is nonzero.
  - Otherwise `hba_abus`, `hba_dbus`, `hba_rnw` and `hba_select` are 0.
- `master_xferack[i]` = `hba_xferack & master_gnt[i]`, combinational. Non-owners always see 0.
- Reset values: state IDLE, `master_gnt` 0, `last` = NUM_MASTERS-1 (so master 0 wins first), counter 0, `timeout_err` 0. All shared outputs are 0.
- Reset mid-transfer: the grant drops immediately and asynchronously, and the bus goes to 0. A transfer in flight is abandoned with no ack.
- Simultaneous release by the owner and a new request: the release completes first, and the new request is evaluated in IDLE.
- A master that drops `req` while its own `select` is high keeps the bus until `select` falls.

## Timing
- Grant latency:
  - `req` first seen high at edge N with the FSM in IDLE → `gnt` high after edge N.
  - The owner may drive `select` from the next cycle onward.
- Release:
  - Owner's `req` and `select` seen low at edge M → `gnt` low after edge M.
  - The next grant is issued at edge M+1 at the earliest. There is exactly one dead cycle between owners.
- Round-robin bound: each requester is served within NUM_MASTERS ownerships.

## Configuration
- `HBA_ARB_TIMEOUT_EN` defined:
  - The counter increments every BUSY cycle.
  - On the cycle the counter equals MAX_HOLD-1 and the owner's `select` is low, the arbiter forces release to IDLE and pulses `timeout_err` for one cycle.
  - If `select` is high at that point, release waits until `select` falls.
  - `last` is left as the timed-out owner, so other requesters are served first.
- `HBA_ARB_TIMEOUT_EN` undefined: no counter logic is built, `timeout_err` is tied to 0, and a master holds the bus indefinitely.

## Test plan
- Reset: assert `reset` mid-BUSY, asynchronously → `master_gnt` = 0 and `hba_select` = 0 before the next edge.
- Grant and mux:
  - Stimulus: m0 requests and writes addr 0x1_05, data 0xA5, slave acks.
  - Required response: `gnt` = 01 one cycle later, `hba_abus` = 0x105, `hba_dbus` = 0xA5, `master_xferack` = 01.
- Round-robin:
  - Stimulus: m0 and m1 both request continuously, each releasing after one transfer.
  - Required response: grants alternate 01, 00, 10, 00, 01, …
- Hold-through-select: owner m1 drops `req` while `select` stays high for 3 cycles → `gnt` remains 10 until `select` falls, then 00.
- Isolation: non-owner m1 toggles `select` and sets addr 0xFFF while m0 owns the bus → shared bus shows m0's values only, and `master_xferack[1]` stays 0.
- Timeout (macro defined, MAX_HOLD = 4):
  - Stimulus: m0 holds `req` with `select` low, m1 requesting.
  - Required response: `timeout_err` pulses on the 4th BUSY cycle, `gnt` goes 00, then 10.

Source files
------------

// File: rtl/hba_master_arbiter.sv
// Round-robin owner arbitration of the shared HBA slave bus: registered one-hot grant one edge after request, one dead cycle between owners.
// Bus held until owner drops req and select; HBA_ARB_TIMEOUT_EN adds a hold watchdog that forces release and pulses timeout_err.
module hba_master_arbiter #(
   parameter int NUM_MASTERS       = 2,
   parameter int DBUS_WIDTH        = 8,
   parameter int PERIPH_ADDR_WIDTH = 4,
   parameter int REG_ADDR_WIDTH    = 8,
   parameter int MAX_HOLD          = 256,
   localparam int ADDR_WIDTH       = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_MASTERS-1:0]            master_req,
   output logic [NUM_MASTERS-1:0]            master_gnt,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] master_abus,
   input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] master_dbus_out,
   input  logic [NUM_MASTERS-1:0]            master_rnw,
   input  logic [NUM_MASTERS-1:0]            master_select,
   output logic [NUM_MASTERS-1:0]            master_xferack,
   output logic [ADDR_WIDTH-1:0]             hba_abus,
   output logic [DBUS_WIDTH-1:0]             hba_dbus,
   output logic                              hba_rnw,
   output logic                              hba_select,
   input  logic                              hba_xferack,
   output logic                              timeout_err
);

   localparam int IDX_W = $clog2(NUM_MASTERS);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                 state, state_nxt;
   logic [IDX_W-1:0]       owner, owner_nxt;
   logic [IDX_W-1:0]       last, last_nxt;
   logic [IDX_W-1:0]       pick;
   logic                   found;
   logic [NUM_MASTERS-1:0] gnt_nxt;
   logic                   owner_done;
   logic                   forced;

`ifdef HBA_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_HOLD);
   logic [CNT_W-1:0] cnt, cnt_nxt;

   // Only a master still requesting with select low can be evicted; a normal release is not a timeout.
   assign forced = (state == BUSY) && (cnt == CNT_W'(MAX_HOLD - 1)) &&
                   master_req[owner] && !master_select[owner];
`else
   assign forced = 1'b0;
`endif

   assign owner_done = !master_req[owner] && !master_select[owner];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= '0;
         last       <= IDX_W'(NUM_MASTERS - 1);
         master_gnt <= '0;
`ifdef HBA_ARB_TIMEOUT_EN
         cnt        <= '0;
`endif
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last       <= last_nxt;
         master_gnt <= gnt_nxt;
`ifdef HBA_ARB_TIMEOUT_EN
         cnt        <= cnt_nxt;
`endif
      end
   end

   // Upward search from last+1, wrapping, so the most recent owner is considered last.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cidx;
      found = 1'b0;
      pick  = last;
      cand  = 0;
      cidx  = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         cand = (int'(last) + k) % NUM_MASTERS;
         cidx = IDX_W'(cand);
         if (!found && master_req[cidx]) begin
            found = 1'b1;
            pick  = cidx;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      gnt_nxt   = master_gnt;
`ifdef HBA_ARB_TIMEOUT_EN
      cnt_nxt   = cnt;
`endif
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = BUSY;
               owner_nxt = pick;
               last_nxt  = pick;
               gnt_nxt   = NUM_MASTERS'(1) << pick;
`ifdef HBA_ARB_TIMEOUT_EN
               cnt_nxt   = '0;
`endif
            end
         end
         BUSY: begin
            if (owner_done || forced) begin
               state_nxt = IDLE;
               gnt_nxt   = '0;
            end
`ifdef HBA_ARB_TIMEOUT_EN
            else if (cnt != CNT_W'(MAX_HOLD - 1)) begin
               cnt_nxt = cnt + 1'b1;
            end
`endif
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      hba_abus    = '0;
      hba_dbus    = '0;
      hba_rnw     = 1'b0;
      hba_select  = 1'b0;
      timeout_err = forced;
      if (|master_gnt) begin
         hba_abus   = master_abus[owner*ADDR_WIDTH +: ADDR_WIDTH];
         hba_dbus   = master_dbus_out[owner*DBUS_WIDTH +: DBUS_WIDTH];
         hba_rnw    = master_rnw[owner];
         hba_select = master_select[owner];
      end
   end

   assign master_xferack = master_gnt & {NUM_MASTERS{hba_xferack}};

endmodule

// File: tb/tb_hba_master_arbiter.sv
// Directed vector bench for hba_master_arbiter with two masters; timeout sequence built only with HBA_ARB_TIMEOUT_EN.
module tb_hba_master_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  master_req;
   logic [1:0]  master_gnt;
   logic [23:0] master_abus;
   logic [15:0] master_dbus_out;
   logic [1:0]  master_rnw;
   logic [1:0]  master_select;
   logic [1:0]  master_xferack;
   logic [11:0] hba_abus;
   logic [7:0]  hba_dbus;
   logic        hba_rnw;
   logic        hba_select;
   logic        hba_xferack;
   logic        timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hba_master_arbiter #(
      .NUM_MASTERS(2), .DBUS_WIDTH(8), .PERIPH_ADDR_WIDTH(4),
      .REG_ADDR_WIDTH(8), .MAX_HOLD(4)
   ) dut (
      .clk(clk), .reset(reset),
      .master_req(master_req), .master_gnt(master_gnt),
      .master_abus(master_abus), .master_dbus_out(master_dbus_out),
      .master_rnw(master_rnw), .master_select(master_select),
      .master_xferack(master_xferack),
      .hba_abus(hba_abus), .hba_dbus(hba_dbus), .hba_rnw(hba_rnw),
      .hba_select(hba_select), .hba_xferack(hba_xferack),
      .timeout_err(timeout_err)
   );

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  sel;
      logic [1:0]  rnw;
      logic        ack;
      logic [1:0]  gnt;
      logic [1:0]  xack;
      logic [11:0] abus;
      logic [7:0]  dbus;
      logic        hrnw;
      logic        hsel;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      // m0: addr 0x105 data 0xA5 write; m1: addr 0xFFF data 0xFF read
      vecs[0]  = '{2'b01, 2'b00, 2'b10, 1'b0, 2'b01, 2'b00, 12'h105, 8'hA5, 1'b0, 1'b0};
      vecs[1]  = '{2'b01, 2'b01, 2'b10, 1'b1, 2'b01, 2'b01, 12'h105, 8'hA5, 1'b0, 1'b1};
      vecs[2]  = '{2'b11, 2'b11, 2'b10, 1'b1, 2'b01, 2'b01, 12'h105, 8'hA5, 1'b0, 1'b1};
      vecs[3]  = '{2'b10, 2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 12'h000, 8'h00, 1'b0, 1'b0};
      vecs[4]  = '{2'b10, 2'b00, 2'b10, 1'b0, 2'b10, 2'b00, 12'hFFF, 8'hFF, 1'b1, 1'b0};
      vecs[5]  = '{2'b00, 2'b10, 2'b10, 1'b1, 2'b10, 2'b10, 12'hFFF, 8'hFF, 1'b1, 1'b1};
      vecs[6]  = '{2'b00, 2'b10, 2'b10, 1'b0, 2'b10, 2'b00, 12'hFFF, 8'hFF, 1'b1, 1'b1};
      vecs[7]  = '{2'b00, 2'b10, 2'b10, 1'b0, 2'b10, 2'b00, 12'hFFF, 8'hFF, 1'b1, 1'b1};
      vecs[8]  = '{2'b00, 2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 12'h000, 8'h00, 1'b0, 1'b0};
      vecs[9]  = '{2'b11, 2'b00, 2'b10, 1'b0, 2'b01, 2'b00, 12'h105, 8'hA5, 1'b0, 1'b0};
      vecs[10] = '{2'b11, 2'b01, 2'b10, 1'b1, 2'b01, 2'b01, 12'h105, 8'hA5, 1'b0, 1'b1};
      vecs[11] = '{2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 12'h000, 8'h00, 1'b0, 1'b0};
      vecs[12] = '{2'b11, 2'b00, 2'b10, 1'b0, 2'b10, 2'b00, 12'hFFF, 8'hFF, 1'b1, 1'b0};
      vecs[13] = '{2'b11, 2'b10, 2'b10, 1'b1, 2'b10, 2'b10, 12'hFFF, 8'hFF, 1'b1, 1'b1};
      vecs[14] = '{2'b01, 2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 12'h000, 8'h00, 1'b0, 1'b0};
      vecs[15] = '{2'b11, 2'b00, 2'b10, 1'b0, 2'b01, 2'b00, 12'h105, 8'hA5, 1'b0, 1'b0};
      vecs[16] = '{2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 12'h000, 8'h00, 1'b0, 1'b0};
      vecs[17] = '{2'b10, 2'b00, 2'b10, 1'b0, 2'b10, 2'b00, 12'hFFF, 8'hFF, 1'b1, 1'b0};
      vecs[18] = '{2'b00, 2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 12'h000, 8'h00, 1'b0, 1'b0};

      reset           = 1'b1;
      master_req      = '0;
      master_select   = '0;
      master_rnw      = 2'b10;
      master_abus     = {12'hFFF, 12'h105};
      master_dbus_out = {8'hFF, 8'hA5};
      hba_xferack     = 1'b0;

      #12;
      check("reset_gnt",     32'(master_gnt),  32'h0);
      check("reset_abus",    32'(hba_abus),    32'h0);
      check("reset_select",  32'(hba_select),  32'h0);
      check("reset_timeout", 32'(timeout_err), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         master_req    = vecs[i].req;
         master_select = vecs[i].sel;
         master_rnw    = vecs[i].rnw;
         hba_xferack   = vecs[i].ack;
         step();
         check($sformatf("v%0d_gnt", i),     32'(master_gnt),     32'(vecs[i].gnt));
         check($sformatf("v%0d_xferack", i), 32'(master_xferack), 32'(vecs[i].xack));
         check($sformatf("v%0d_abus", i),    32'(hba_abus),       32'(vecs[i].abus));
         check($sformatf("v%0d_dbus", i),    32'(hba_dbus),       32'(vecs[i].dbus));
         check($sformatf("v%0d_rnw", i),     32'(hba_rnw),        32'(vecs[i].hrnw));
         check($sformatf("v%0d_select", i),  32'(hba_select),     32'(vecs[i].hsel));
         check($sformatf("v%0d_timeout", i), 32'(timeout_err),    32'h0);
      end

      // Asynchronous reset while m0 is mid-transfer
      @(negedge clk);
      master_req = 2'b01; master_select = 2'b00; hba_xferack = 1'b0;
      step();
      check("rst_pre_gnt", 32'(master_gnt), 32'h1);
      @(negedge clk);
      master_select = 2'b01; hba_xferack = 1'b1;
      #1;
      check("rst_pre_select", 32'(hba_select), 32'h1);
      reset = 1'b1;
      #1;
      check("rst_async_gnt",     32'(master_gnt),     32'h0);
      check("rst_async_select",  32'(hba_select),     32'h0);
      check("rst_async_xferack", 32'(master_xferack), 32'h0);
      check("rst_async_abus",    32'(hba_abus),       32'h0);
      @(negedge clk);
      reset = 1'b0;
      master_req = 2'b11; master_select = 2'b00; hba_xferack = 1'b0;
      step();
      check("rst_first_winner_m0", 32'(master_gnt), 32'h1);
      @(negedge clk);
      master_req = 2'b00;
      step();
      check("rst_release_gnt", 32'(master_gnt), 32'h0);

`ifdef HBA_ARB_TIMEOUT_EN
      // m0 holds req with select low, m1 waiting: forced release on 4th BUSY cycle
      @(negedge clk);
      reset = 1'b1;
      #1;
      reset = 1'b0;
      master_req = 2'b11; master_select = 2'b00;
      step();
      check("to_c1_gnt", 32'(master_gnt), 32'h1);
      check("to_c1_err", 32'(timeout_err), 32'h0);
      step();
      check("to_c2_err", 32'(timeout_err), 32'h0);
      step();
      check("to_c3_err", 32'(timeout_err), 32'h0);
      check("to_c3_gnt", 32'(master_gnt), 32'h1);
      step();
      check("to_c4_err", 32'(timeout_err), 32'h1);
      check("to_c4_gnt", 32'(master_gnt), 32'h1);
      step();
      check("to_dead_gnt", 32'(master_gnt), 32'h0);
      check("to_dead_err", 32'(timeout_err), 32'h0);
      step();
      check("to_next_gnt_m1", 32'(master_gnt), 32'h2);
      @(negedge clk);
      master_req = 2'b00;
      step();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
